// File: rtl/codificador_7seg_hexadecimal.sv
// Segment-pattern to hex encoder: debounces a 7-segment bus, maps valid glyphs
// back to 0x0..0xF and hands each newly stable digit out once over valid/ready.
module codificador_7seg_hexadecimal #(
    parameter int ESTABLE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg,
    input  logic       listo,
    output logic [3:0] hex,
    output logic       valido,
    output logic       error
);

    localparam logic [7:0] EST = 8'(ESTABLE);

    typedef enum logic {ESPERA, PRESENTA} estado_t;

    estado_t    state;
    logic [6:0] seg_q;
    logic [6:0] ultimo;
    logic [7:0] cnt;
    logic       glifo_ok;
    logic [3:0] codigo;

    always_comb begin
        glifo_ok = 1'b1;
        codigo   = 4'h0;
        case (seg_q)
            7'h7E: codigo = 4'h0;
            7'h30: codigo = 4'h1;
            7'h6D: codigo = 4'h2;
            7'h79: codigo = 4'h3;
            7'h33: codigo = 4'h4;
            7'h5B: codigo = 4'h5;
            7'h5F: codigo = 4'h6;
            7'h70: codigo = 4'h7;
            7'h7F: codigo = 4'h8;
            7'h7B: codigo = 4'h9;
            7'h77: codigo = 4'hA;
            7'h1F: codigo = 4'hB;
            7'h4E: codigo = 4'hC;
            7'h3D: codigo = 4'hD;
            7'h4F: codigo = 4'hE;
            7'h47: codigo = 4'hF;
            default: glifo_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ESPERA;
            seg_q  <= 7'h00;
            ultimo <= 7'h00;
            cnt    <= 8'd0;
            hex    <= 4'h0;
            valido <= 1'b0;
            error  <= 1'b0;
        end else begin
            // Filter runs in both states so a pattern settled during PRESENTA
            // is ready for evaluation on the first ESPERA cycle.
            seg_q <= seg;
            if (seg != seg_q)
                cnt <= 8'd1;
            else if (cnt < EST)
                cnt <= cnt + 8'd1;

            error <= 1'b0;
            case (state)
                ESPERA: begin
                    if (cnt == EST) begin
                        if (seg_q == 7'h00) begin
                            ultimo <= 7'h00;
                        end else if (seg_q != ultimo) begin
                            ultimo <= seg_q;
                            if (glifo_ok) begin
                                hex    <= codigo;
                                valido <= 1'b1;
                                state  <= PRESENTA;
                            end else begin
                                error <= 1'b1;
                            end
                        end
                    end
                end
                PRESENTA: begin
                    if (listo) begin
                        valido <= 1'b0;
                        state  <= ESPERA;
                    end
                end
                default: state <= ESPERA;
            endcase
        end
    end

endmodule
